// File: rtl/uart_echo_tester.sv
// Host-side UART echo sequencer: sends incrementing 8N1 bytes, checks each echo, counts errors.
// txd falls one cycle after an accepted start; done pulses one cycle after the last NEXT.
module uart_echo_tester #(
  parameter int CLKS_PER_BIT = 434,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] seed,
  input  logic [7:0] count,
  input  logic       rxd,
  output logic       txd,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count,
  output logic [7:0] last_rx
);

  localparam int CW     = $clog2(CLKS_PER_BIT);
  localparam int TO_CYC = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW     = $clog2(TO_CYC);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TO_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_NEXT} state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA} rx_state_t;

  state_t          state;
  logic [7:0]      byte_val;
  logic [8:0]      remaining;
  logic [3:0]      tx_bit;
  logic [CW-1:0]   tx_cnt;
  logic [TW-1:0]   to_cnt;
  logic            to_flag;

  rx_state_t       rx_state;
  logic            rx_s1, rx_s2, rx_s3;
  logic [CW-1:0]   rx_cnt;
  logic [3:0]      rx_bit;
  logic [7:0]      rx_sh;
  logic            rx_vld;
  logic            rx_ferr;

  logic            rx_clr;
  logic            byte_err;

  // Holding register is armed fresh at the first cycle of every start bit we send.
  assign rx_clr   = (state == S_SEND) && (tx_bit == 4'd0) && (tx_cnt == '0);
  assign byte_err = to_flag || rx_ferr || (last_rx != byte_val);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      txd       <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 8'd0;
      byte_val  <= 8'd0;
      remaining <= 9'd0;
      tx_bit    <= 4'd0;
      tx_cnt    <= '0;
      to_cnt    <= '0;
      to_flag   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          // A start coinciding with done belongs to the run that just ended.
          if (start && !done) begin
            byte_val  <= seed;
            remaining <= (count == 8'd0) ? 9'd256 : {1'b0, count};
            err_count <= 8'd0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            txd       <= 1'b0;
            tx_bit    <= 4'd0;
            tx_cnt    <= '0;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_bit == 4'd9) begin
              to_cnt  <= '0;
              to_flag <= 1'b0;
              state   <= S_WAIT;
            end else begin
              tx_bit <= tx_bit + 4'd1;
              txd    <= (tx_bit == 4'd8) ? 1'b1 : byte_val[tx_bit[2:0]];
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_WAIT: begin
          if (rx_vld) begin
            state <= S_NEXT;
          end else if (to_cnt == TO_LAST) begin
            to_flag <= 1'b1;
            state   <= S_NEXT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_NEXT: begin
          byte_val  <= byte_val + 8'd1;
          remaining <= remaining - 9'd1;
          if (byte_err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
          if (remaining == 9'd1) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            pass  <= (err_count == 8'd0) && !byte_err;
            state <= S_IDLE;
          end else begin
            txd    <= 1'b0;
            tx_bit <= 4'd0;
            tx_cnt <= '0;
            state  <= S_SEND;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 4'd0;
      rx_sh    <= 8'd0;
      rx_vld   <= 1'b0;
      rx_ferr  <= 1'b0;
      last_rx  <= 8'd0;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
      if (rx_clr) begin
        rx_vld  <= 1'b0;
        rx_ferr <= 1'b0;
      end
      case (rx_state)
        RX_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= RX_START;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bit   <= 4'd0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_bit == 4'd8) begin
              last_rx  <= rx_sh;
              rx_vld   <= 1'b1;
              rx_ferr  <= !rx_s2;
              rx_state <= RX_IDLE;
            end else begin
              rx_sh  <= {rx_s2, rx_sh[7:1]};
              rx_bit <= rx_bit + 4'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_echo_tester.sv
// Directed bench for uart_echo_tester: wire loopback, corrupting echo peer, dead line, reset abort.
module tb_uart_echo_tester;

  localparam int CPB = 16;
  localparam int TOB = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed = 8'd0;
  logic [7:0] count = 8'd0;
  logic       rxd;
  logic       txd, busy, done, pass;
  logic [7:0] err_count, last_rx;

  int         mode = 0;          // 0 wire loopback, 1 line held high, 2 echo peer
  logic       echo_line = 1'b1;
  logic       echo_req = 1'b0;
  logic [7:0] echo_byte = 8'd0;
  logic       echo_stop = 1'b1;
  logic [7:0] cur_seed = 8'd0;
  int         xor_idx = -1;
  int         ferr_idx = -1;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int cyc = 0;

  uart_echo_tester #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TOB)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .seed(seed), .count(count), .rxd(rxd),
    .txd(txd), .busy(busy), .done(done), .pass(pass), .err_count(err_count), .last_rx(last_rx)
  );

  always #5 clk = ~clk;

  assign rxd = (mode == 0) ? txd : (mode == 1) ? 1'b1 : echo_line;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  // Echo peer: decode what the DUT sends, hand it to the sender with optional corruption.
  always begin : echo_rx
    logic [7:0] b;
    int idx;
    @(negedge txd);
    repeat (8) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      repeat (16) @(posedge clk);
      b[i] = txd;
    end
    repeat (16) @(posedge clk);
    idx = int'(8'(b - cur_seed));
    echo_byte = (idx == xor_idx) ? (b ^ 8'h01) : b;
    echo_stop = (idx == ferr_idx) ? 1'b0 : 1'b1;
    echo_req = ~echo_req;
  end

  always begin : echo_tx
    logic [9:0] fr;
    @(echo_req);
    fr = {echo_stop, echo_byte, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      echo_line = fr[i];
      repeat (15) @(negedge clk);
    end
    @(negedge clk);
    echo_line = 1'b1;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_w(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] wave(input logic [7:0] b);
    logic [159:0] w;
    for (int j = 0; j < 160; j++) begin
      if (j < 16)       w[j] = 1'b0;
      else if (j >= 144) w[j] = 1'b1;
      else              w[j] = b[j/16 - 1];
    end
    return w;
  endfunction

  task automatic pulse_start(input logic [7:0] s, input logic [7:0] c);
    @(negedge clk);
    seed = s;
    count = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records one cycle per sample of a frame, from its first low cycle through the stop bit.
  task automatic get_frame(input bit poke, output logic [159:0] fw, output int t_fall);
    int w = 0;
    fw = 'x;
    t_fall = -1;
    while (txd !== 1'b0 && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (txd !== 1'b0) begin
      check("frame_start", 32'(txd), 32'd0);
      return;
    end
    t_fall = cyc;
    for (int j = 0; j < 160; j++) begin
      fw[j] = txd;
      if (poke && j == 80) begin
        start = 1'b1;
        seed = 8'h00;
        count = 8'h01;
      end
      if (poke && j == 81) start = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic wait_done(input int limit);
    int w = 0;
    while (done !== 1'b1 && w < limit) begin
      @(negedge clk);
      w++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  initial begin
    logic [159:0] fw;
    int t1, t2, dc0, bad;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_txd", 32'(txd), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_pass", 32'(pass), 32'd0);
    check("rst_err", 32'(err_count), 32'd0);
    check("rst_last_rx", 32'(last_rx), 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Wire loopback, 0x41..0x44
    mode = 0;
    pulse_start(8'h41, 8'd4);
    check("s1_txd_low", 32'(txd), 32'd0);
    check("s1_busy", 32'(busy), 32'd1);
    for (int k = 0; k < 4; k++) begin
      get_frame(1'b0, fw, t1);
      check_w("s1_frame", fw, wave(8'(8'h41 + k)));
      check("s1_post_idle", 32'(txd), 32'd1);
    end
    wait_done(100);
    check("s1_pass", 32'(pass), 32'd1);
    check("s1_err", 32'(err_count), 32'd0);
    check("s1_last_rx", 32'(last_rx), 32'h44);
    check("s1_busy_done", 32'(busy), 32'd0);
    start = 1'b1;
    seed = 8'h99;
    count = 8'd1;
    @(negedge clk);
    start = 1'b0;
    check("s1_done_width", 32'(done), 32'd0);
    check("s1_start_on_done_busy", 32'(busy), 32'd0);
    check("s1_start_on_done_txd", 32'(txd), 32'd1);
    check("s1_pass_held", 32'(pass), 32'd1);
    repeat (200) @(negedge clk);

    // Echo corrupts third byte
    mode = 2;
    cur_seed = 8'h10;
    xor_idx = 2;
    ferr_idx = -1;
    pulse_start(8'h10, 8'd5);
    wait_done(5000);
    check("s2_err", 32'(err_count), 32'd1);
    check("s2_pass", 32'(pass), 32'd0);
    check("s2_last_rx", 32'(last_rx), 32'h14);
    repeat (200) @(negedge clk);

    // Dead line: both bytes time out
    mode = 1;
    xor_idx = -1;
    dc0 = done_cnt;
    pulse_start(8'h60, 8'd2);
    get_frame(1'b0, fw, t1);
    check_w("s3_frame0", fw, wave(8'h60));
    get_frame(1'b0, fw, t2);
    check_w("s3_frame1", fw, wave(8'h61));
    check("s3_frame_spacing", 32'(t2 - t1), 32'd481);
    wait_done(1000);
    check("s3_err", 32'(err_count), 32'd2);
    check("s3_pass", 32'(pass), 32'd0);
    repeat (600) @(negedge clk);
    check("s3_done_once", 32'(done_cnt - dc0), 32'd1);
    check("s3_err_held", 32'(err_count), 32'd2);

    // Echo stop bit low on first byte
    mode = 2;
    cur_seed = 8'h20;
    ferr_idx = 0;
    pulse_start(8'h20, 8'd3);
    wait_done(5000);
    check("s4_err", 32'(err_count), 32'd1);
    check("s4_pass", 32'(pass), 32'd0);
    check("s4_last_rx", 32'(last_rx), 32'h22);
    ferr_idx = -1;
    repeat (200) @(negedge clk);

    // 256-byte wrap with a stray start mid-run
    mode = 0;
    dc0 = done_cnt;
    bad = 0;
    pulse_start(8'hFF, 8'd0);
    for (int k = 0; k < 256; k++) begin
      get_frame(k == 10, fw, t1);
      if (fw !== wave(8'(8'hFF + k))) bad++;
    end
    check("s5_bad_frames", 32'(bad), 32'd0);
    wait_done(100);
    check("s5_err", 32'(err_count), 32'd0);
    check("s5_pass", 32'(pass), 32'd1);
    check("s5_last_rx", 32'(last_rx), 32'hFE);
    repeat (400) @(negedge clk);
    check("s5_done_once", 32'(done_cnt - dc0), 32'd1);
    check("s5_txd_idle", 32'(txd), 32'd1);

    // Reset during d3 of the first frame
    dc0 = done_cnt;
    pulse_start(8'h33, 8'd1);
    repeat (69) @(negedge clk);
    check("s6_d3_low", 32'(txd), 32'd0);
    check("s6_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("s6_rst_txd", 32'(txd), 32'd1);
    check("s6_rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("s6_no_done", 32'(done_cnt - dc0), 32'd0);
    check("s6_idle_txd", 32'(txd), 32'd1);
    pulse_start(8'h55, 8'd1);
    get_frame(1'b0, fw, t1);
    check_w("s6_frame", fw, wave(8'h55));
    wait_done(100);
    check("s6_pass", 32'(pass), 32'd1);
    check("s6_err", 32'(err_count), 32'd0);
    check("s6_last_rx", 32'(last_rx), 32'h55);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
